// File: rtl/reset_seq.sv
// Power-on / re-arm reset sequencer: synchronizes reset requests, debounces their release,
// then releases NUM_CH reset domains in ascending order with a fixed gap between them.
module reset_seq #(
   parameter int NUM_CH       = 4,
   parameter int DEBOUNCE_CYC = 16,
   parameter int GAP_CYC      = 8
) (
   input  logic              SYS_CLK,
   input  logic              SYS_RST_N,
   input  logic              SYS_CLK_STABLE,
   input  logic              BOARD_RST_SW,
   input  logic              SL_RST_N,
   output logic [NUM_CH-1:0] RST_N_OUT,
   output logic              RST_DONE,
   output logic [2:0]        RST_CAUSE,
   output logic [7:0]        RST_CNT
);

   localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam int GW = (GAP_CYC > 1)      ? $clog2(GAP_CYC)      : 1;
   localparam int CW = (NUM_CH > 1)       ? $clog2(NUM_CH)       : 1;

   localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYC - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
   localparam logic [CW-1:0] CH_LAST  = CW'(NUM_CH - 1);

   // Synchronizer bit order is {sl_rst_n, sw, stable}; reset value keeps the request active.
   localparam logic [2:0] SYNC_RST = 3'b010;

   typedef enum logic [1:0] {
      S_HOLD     = 2'd0,
      S_DEBOUNCE = 2'd1,
      S_RELEASE  = 2'd2,
      S_RUN      = 2'd3
   } state_e;

   logic [2:0]        meta_q, sync_q;
   logic              stable_s, sw_s, sl_rst_n_s;
   logic              req;
   logic [2:0]        cause_now;

   state_e            state_q, state_d;
   logic [DW-1:0]     db_cnt_q, db_cnt_d;
   logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
   logic [CW-1:0]     ch_q, ch_d;
   logic [NUM_CH-1:0] rst_n_q, rst_n_d;
   logic              done_q, done_d;
   logic [2:0]        cause_q, cause_d;
   logic [7:0]        cnt_q, cnt_d;

   always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
      if (!SYS_RST_N) begin
         meta_q <= SYNC_RST;
         sync_q <= SYNC_RST;
      end else begin
         meta_q <= {SL_RST_N, BOARD_RST_SW, SYS_CLK_STABLE};
         sync_q <= meta_q;
      end
   end

   assign stable_s   = sync_q[0];
   assign sw_s       = sync_q[1];
   assign sl_rst_n_s = sync_q[2];
   assign req        = ~stable_s | sw_s | ~sl_rst_n_s;
   assign cause_now  = {~sl_rst_n_s, sw_s, ~stable_s};

   always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
      if (!SYS_RST_N) begin
         state_q   <= S_HOLD;
         db_cnt_q  <= '0;
         gap_cnt_q <= '0;
         ch_q      <= '0;
         rst_n_q   <= '0;
         done_q    <= 1'b0;
         cause_q   <= 3'b000;
         cnt_q     <= 8'd0;
      end else begin
         state_q   <= state_d;
         db_cnt_q  <= db_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         ch_q      <= ch_d;
         rst_n_q   <= rst_n_d;
         done_q    <= done_d;
         cause_q   <= cause_d;
         cnt_q     <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_HOLD: begin
            if (!req) state_d = S_DEBOUNCE;
         end
         S_DEBOUNCE: begin
            if (req)                        state_d = S_HOLD;
            else if (db_cnt_q == DB_LAST)   state_d = (NUM_CH == 1) ? S_RUN : S_RELEASE;
         end
         S_RELEASE: begin
            if (req)                                           state_d = S_HOLD;
            else if (gap_cnt_q == GAP_LAST && ch_q == CH_LAST) state_d = S_RUN;
         end
         S_RUN: begin
            if (req) state_d = S_HOLD;
         end
         default: state_d = S_HOLD;
      endcase
   end

   // Outputs are registered: these are the values the outputs take on the coming edge.
   always_comb begin
      db_cnt_d  = db_cnt_q;
      gap_cnt_d = gap_cnt_q;
      ch_d      = ch_q;
      rst_n_d   = rst_n_q;
      done_d    = done_q;
      cause_d   = cause_q;
      cnt_d     = cnt_q;
      case (state_q)
         S_HOLD: begin
            db_cnt_d  = '0;
            gap_cnt_d = '0;
            ch_d      = '0;
            rst_n_d   = '0;
            done_d    = 1'b0;
         end
         S_DEBOUNCE: begin
            if (req) begin
               db_cnt_d = '0;
               rst_n_d  = '0;
               done_d   = 1'b0;
            end else if (db_cnt_q == DB_LAST) begin
               db_cnt_d   = '0;
               gap_cnt_d  = '0;
               ch_d       = CW'(1);
               rst_n_d[0] = 1'b1;
               done_d     = (NUM_CH == 1);
            end else begin
               db_cnt_d = db_cnt_q + 1'b1;
            end
         end
         S_RELEASE, S_RUN: begin
            if (req) begin
               db_cnt_d  = '0;
               gap_cnt_d = '0;
               ch_d      = '0;
               rst_n_d   = '0;
               done_d    = 1'b0;
               cause_d   = cause_now;
               cnt_d     = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
            end else if (state_q == S_RELEASE) begin
               if (gap_cnt_q == GAP_LAST) begin
                  gap_cnt_d = '0;
                  for (int k = 0; k < NUM_CH; k++)
                     if (ch_q == CW'(k)) rst_n_d[k] = 1'b1;
                  if (ch_q == CH_LAST) done_d = 1'b1;
                  else                 ch_d   = ch_q + 1'b1;
               end else begin
                  gap_cnt_d = gap_cnt_q + 1'b1;
               end
            end
         end
         default: begin
            rst_n_d = '0;
            done_d  = 1'b0;
         end
      endcase
   end

   assign RST_N_OUT = rst_n_q;
   assign RST_DONE  = done_q;
   assign RST_CAUSE = cause_q;
   assign RST_CNT   = cnt_q;

endmodule

// File: tb/tb_reset_seq.sv
// Scoreboard bench for reset_seq: a default 4-channel instance and a minimal 1-channel instance.
module tb_reset_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int edges = 0;
   always @(posedge clk) edges <= edges + 1;

   logic       rst_n_a, stable_a, sw_a, sl_a;
   logic [3:0] rst_out_a;
   logic       done_a;
   logic [2:0] cause_a;
   logic [7:0] cnt_a;

   logic       rst_n_b, stable_b, sw_b, sl_b;
   logic [0:0] rst_out_b;
   logic       done_b;
   logic [2:0] cause_b;
   logic [7:0] cnt_b;

   reset_seq u_dut_a (
      .SYS_CLK(clk), .SYS_RST_N(rst_n_a), .SYS_CLK_STABLE(stable_a),
      .BOARD_RST_SW(sw_a), .SL_RST_N(sl_a), .RST_N_OUT(rst_out_a),
      .RST_DONE(done_a), .RST_CAUSE(cause_a), .RST_CNT(cnt_a)
   );

   reset_seq #(.NUM_CH(1), .DEBOUNCE_CYC(1), .GAP_CYC(1)) u_dut_b (
      .SYS_CLK(clk), .SYS_RST_N(rst_n_b), .SYS_CLK_STABLE(stable_b),
      .BOARD_RST_SW(sw_b), .SL_RST_N(sl_b), .RST_N_OUT(rst_out_b),
      .RST_DONE(done_b), .RST_CAUSE(cause_b), .RST_CNT(cnt_b)
   );

   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      string tag;
      int    exp;
      int    tol;
   } exp_t;
   exp_t sb_q[$];

   task automatic chk(input string tag, input int got, input int exp, input int tol = 0);
      n_chk++;
      if (got < exp - tol || got > exp + tol) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
      end
   endtask

   task automatic push(input string tag, input int exp, input int tol = 0);
      exp_t e;
      e.tag = tag;
      e.exp = exp;
      e.tol = tol;
      sb_q.push_back(e);
   endtask

   task automatic pop_chk(input int got);
      exp_t e;
      if (sb_q.size() == 0) begin
         chk("sb_underflow", 1, 0);
      end else begin
         e = sb_q.pop_front();
         chk(e.tag, got, e.exp, e.tol);
      end
   endtask

   // Drive just after a rising edge; 'edges' then names that edge.
   task automatic drive_a(input logic st, input logic sw, input logic sl);
      @(posedge clk); #2;
      stable_a = st; sw_a = sw; sl_a = sl;
   endtask

   // idx 0..3 = channel, 4 = done. Returns edge number of the rise, -1 on timeout.
   task automatic wait_rise(input bit sel_b, input int idx, input int budget, output int at);
      logic cur;
      at = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (sel_b) cur = (idx == 4) ? done_b : rst_out_b[0];
         else       cur = (idx == 4) ? done_a : rst_out_a[idx];
         if (cur) begin
            at = edges;
            break;
         end
      end
      if (at < 0) chk($sformatf("timeout_rise_%0d_%0d", sel_b, idx), 0, 1);
   endtask

   task automatic wait_low(input bit sel_b, input int budget, output int at);
      logic busy;
      at = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         busy = sel_b ? (rst_out_b != 0 || done_b) : (rst_out_a != 0 || done_a);
         if (!busy) begin
            at = edges;
            break;
         end
      end
      if (at < 0) chk($sformatf("timeout_low_%0d", sel_b), 0, 1);
   endtask

   int d, d2, at, at0, at1, at2, at3, lat, bad;

   initial begin
      rst_n_a = 1'b0; stable_a = 1'b1; sw_a = 1'b0; sl_a = 1'b1;
      rst_n_b = 1'b0; stable_b = 1'b1; sw_b = 1'b0; sl_b = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out", rst_out_a, 0);
      chk("rst_done", done_a, 0);
      chk("rst_cause", cause_a, 0);
      chk("rst_cnt", cnt_a, 0);

      // Power-up sequence with clean inputs
      @(posedge clk); #2;
      rst_n_a = 1'b1; d = edges;
      push("ch0_lat", d + 19, 1);
      push("ch1_gap", 8);
      push("ch2_gap", 16);
      push("ch3_gap", 24);
      push("done_vs_ch3", 0);
      wait_rise(0, 0, 60, at0); pop_chk(at0); lat = at0 - d;
      wait_rise(0, 1, 20, at1); pop_chk(at1 - at0);
      chk("order_ch1", rst_out_a, 4'b0011);
      wait_rise(0, 2, 20, at2); pop_chk(at2 - at0);
      chk("done_early", done_a, 0);
      wait_rise(0, 3, 20, at3); pop_chk(at3 - at0);
      if (done_a) pop_chk(0);
      else begin wait_rise(0, 4, 20, at); pop_chk(at - at3); end
      chk("pwrup_cnt", cnt_a, 0);
      chk("pwrup_cause", cause_a, 0);

      // Lock loss in RUN
      drive_a(1'b0, 1'b0, 1'b1); d = edges;
      push("lock_hold_edge", d + 3);
      wait_low(0, 10, at); pop_chk(at);
      chk("lock_cause", cause_a, 3'b001);
      chk("lock_cnt", cnt_a, 1);

      // Switch glitch at debounce count 10 restarts the full debounce
      drive_a(1'b1, 1'b0, 1'b1); d = edges;
      repeat (13) @(posedge clk); #2;
      sw_a = 1'b1;
      repeat (5) @(posedge clk); #2;
      sw_a = 1'b0; d2 = edges;
      push("deb_restart", d2 + lat);
      wait_rise(0, 0, 60, at); pop_chk(at);
      chk("deb_cause", cause_a, 3'b001);
      chk("deb_cnt", cnt_a, 1);
      wait_rise(0, 4, 60, at);

      // Host + switch together during RELEASE
      drive_a(1'b0, 1'b0, 1'b1);
      wait_low(0, 10, at);
      drive_a(1'b1, 1'b0, 1'b1);
      wait_rise(0, 1, 80, at);
      drive_a(1'b1, 1'b1, 1'b0); d = edges;
      push("dual_hold_edge", d + 3);
      wait_low(0, 10, at); pop_chk(at);
      chk("dual_cause", cause_a, 3'b110);
      chk("dual_cnt", cnt_a, 3);
      bad = 0;
      repeat (30) begin @(negedge clk); if (rst_out_a != 0 || done_a) bad++; end
      chk("dual_held", bad, 0);
      sl_a = 1'b1;
      bad = 0;
      repeat (30) begin @(negedge clk); if (rst_out_a != 0 || done_a) bad++; end
      chk("sw_only_held", bad, 0);
      drive_a(1'b1, 1'b0, 1'b1); d = edges;
      push("dual_restart", d + lat);
      wait_rise(0, 0, 60, at); pop_chk(at);
      wait_rise(0, 4, 60, at);

      // Asynchronous reset mid-sequence
      drive_a(1'b0, 1'b0, 1'b1);
      wait_low(0, 10, at);
      drive_a(1'b1, 1'b0, 1'b1);
      wait_rise(0, 1, 80, at);
      #1 rst_n_a = 1'b0;
      #1;
      chk("async_out", rst_out_a, 0);
      chk("async_cnt", cnt_a, 0);
      chk("async_cause", cause_a, 0);
      @(posedge clk); #2;
      rst_n_a = 1'b1; d = edges;
      push("post_rst_restart", d + lat);
      wait_rise(0, 0, 60, at); pop_chk(at);
      wait_rise(0, 4, 60, at);

      // Re-entry counter saturation
      for (int i = 1; i <= 300; i++) begin
         drive_a(1'b0, 1'b0, 1'b1);
         push($sformatf("cnt_%0d", i), (i < 255) ? i : 255);
         wait_low(0, 10, at); pop_chk(cnt_a);
         drive_a(1'b1, 1'b0, 1'b1);
         wait_rise(0, 4, 80, at);
      end
      chk("sat_cnt", cnt_a, 255);
      chk("sat_cause", cause_a, 3'b001);

      // Single-channel, minimal timing
      @(posedge clk); #2;
      rst_n_b = 1'b1; d = edges;
      push("b_ch0_edge", d + 4);
      push("b_done_same", 1);
      wait_rise(1, 0, 20, at); pop_chk(at); pop_chk(done_b);
      @(posedge clk); #2;
      stable_b = 1'b0; d = edges;
      push("b_hold_edge", d + 3);
      wait_low(1, 10, at); pop_chk(at);
      chk("b_cause", cause_b, 3'b001);
      chk("b_cnt", cnt_b, 1);

      chk("sb_drained", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_err, n_chk);
      $fatal(1);
   end

endmodule
